// File: rtl/top_entity.sv
// top_entity: runtime monitor, one event input x, nine event-paced and five periodic streams,
// evaluated from an entry FIFO in three layers. TOP_ENTITY_DEBUG_TAPS_EN enables the h/g/n debug taps.
module top_entity #(
  parameter int PERIOD_CYCLES = 500,
  parameter int QDEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic signed [63:0] input_0,
  input  logic new_input_0,
  output logic signed [63:0] output_0,
  output logic output_0_aktv,
  output logic signed [63:0] output_1,
  output logic output_1_aktv,
  output logic signed [63:0] output_2,
  output logic output_2_aktv,
  output logic signed [63:0] output_3,
  output logic output_3_aktv,
  output logic signed [63:0] output_4,
  output logic output_4_aktv,
  output logic signed [63:0] output_5,
  output logic output_5_aktv,
  output logic signed [63:0] output_6,
  output logic output_6_aktv,
  output logic signed [63:0] output_7,
  output logic output_7_aktv,
  output logic signed [63:0] output_8,
  output logic output_8_aktv,
  output logic signed [63:0] output_9,
  output logic output_9_aktv,
  output logic signed [63:0] output_10,
  output logic output_10_aktv,
  output logic signed [63:0] output_11,
  output logic output_11_aktv,
  output logic signed [63:0] output_12,
  output logic output_12_aktv,
  output logic signed [63:0] output_13,
  output logic output_13_aktv,
  output logic q_push,
  output logic q_pop,
  output logic q_push_valid,
  output logic q_pop_valid,
  output logic pacing_0,
  output logic pacing_1,
  output logic pacing_2,
  output logic pacing_3,
  output logic pacing_4,
  output logic pacing_5,
  output logic pacing_6,
  output logic pacing_7,
  output logic pacing_8,
  output logic pacing_9,
  output logic pacing_10,
  output logic pacing_11,
  output logic pacing_12,
  output logic pacing_13,
  output logic [7:0] h_tag,
  output logic [63:0] h,
  output logic [7:0] g_tag,
  output logic [63:0] g,
  output logic [7:0] n_tag,
  output logic [63:0] n,
  output logic [7:0] h_t
);
  localparam int AW = $clog2(QDEPTH);
  typedef enum logic [1:0] {IDLE, L1, L2, L3} state_t;
  state_t state, state_nx;
  logic [31:0] pc;
  logic [AW:0] wp, rp;
  logic [AW-1:0] wa, ra;
  logic signed [63:0] mx [QDEPTH];
  logic [13:0] mp [QDEPTH];
  logic tick, full, empty;
  logic signed [63:0] ex, hx;
  logic signed [63:0] o [14];
  logic signed [63:0] t [14];
  logic signed [63:0] nv [14];
  logic [13:0] ep, ak, pac;
  assign wa = wp[AW-1:0];
  assign ra = rp[AW-1:0];
  assign tick = pc == 32'(PERIOD_CYCLES - 1);
  assign empty = wp == rp;
  assign full = (wa == ra) && (wp[AW] != rp[AW]);
  assign q_push = en && (new_input_0 || tick);
  assign q_push_valid = q_push && !full;
  assign q_pop_valid = q_pop && !empty;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc <= '0;
      wp <= '0;
      rp <= '0;
    end else if (en) begin
      pc <= tick ? '0 : pc + 32'd1;
      if (q_push_valid) wp <= wp + (AW+1)'(1);
      if (q_pop_valid) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (q_push_valid) begin
      mx[wa] <= input_0;
      mp[wa] <= {{5{tick}}, {9{new_input_0}}};
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else if (en) state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (q_pop_valid ? L1 : IDLE) :
               state == L1 ? L2 : state == L2 ? L3 : IDLE;
  always_comb begin
    q_pop = en && state == IDLE;
    pac = state == IDLE ? '0 : ep;
  end
  // L3 results; layer-1/2 values come from t, held values from o
  always_comb begin
    nv = t;
    nv[6] = t[3] + t[4];
    nv[7] = o[7] + ex;
    nv[8] = t[3] - t[5];
    nv[13] = t[11] + t[12];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ex <= '0;
      hx <= '0;
      ep <= '0;
      ak <= '0;
      for (int i = 0; i < 14; i++) begin
        o[i] <= '0;
        t[i] <= '0;
      end
    end else if (en) begin
      ak <= '0;
      if (q_pop_valid) begin
        ex <= mx[ra];
        ep <= mp[ra];
      end
      if (state == L1) begin
        t[0] <= ex + 64'sd1;
        t[1] <= ex <<< 1;
        t[2] <= ex - 64'sd1;
        t[9] <= o[9] + 64'sd1;
        t[10] <= ep[0] ? ex : hx;
      end
      if (state == L2) begin
        t[3] <= t[0] + t[1];
        t[4] <= t[1] - t[2];
        t[5] <= t[0] + t[2] + ex;
        t[11] <= o[7] + t[9];
        t[12] <= o[6] - t[10];
      end
      if (state == L3) begin
        for (int i = 0; i < 14; i++)
          if (ep[i]) o[i] <= nv[i];
        ak <= ep;
        if (ep[0]) hx <= ex;
      end
    end
`ifdef TOP_ENTITY_DEBUG_TAPS_EN
  logic [7:0] tag, cyc, etag, g_tag_r, n_tag_r;
  logic [7:0] mt [QDEPTH];
  logic [7:0] ms [QDEPTH];
  logic [63:0] g_r, n_r;
  always_ff @(posedge clk)
    if (q_push_valid) begin
      mt[wa] <= tag;
      ms[wa] <= cyc;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tag <= '0;
      cyc <= '0;
      etag <= '0;
      g_tag_r <= '0;
      n_tag_r <= '0;
      g_r <= '0;
      n_r <= '0;
    end else if (en) begin
      cyc <= cyc + 8'd1;
      if (q_push_valid) tag <= tag + 8'd1;
      if (q_pop_valid) etag <= mt[ra];
      if (state == L3 && ep[0]) begin
        g_tag_r <= etag;
        g_r <= nv[6];
      end
      if (state == L3 && ep[9]) begin
        n_tag_r <= etag;
        n_r <= nv[13];
      end
    end
  assign h_tag = empty ? '0 : mt[ra];
  assign h = empty ? '0 : mx[ra];
  assign h_t = empty ? '0 : ms[ra];
  assign g_tag = g_tag_r;
  assign g = g_r;
  assign n_tag = n_tag_r;
  assign n = n_r;
`else
  assign h_tag = '0;
  assign h = '0;
  assign h_t = '0;
  assign g_tag = '0;
  assign g = '0;
  assign n_tag = '0;
  assign n = '0;
`endif
  assign output_0 = o[0];
  assign output_1 = o[1];
  assign output_2 = o[2];
  assign output_3 = o[3];
  assign output_4 = o[4];
  assign output_5 = o[5];
  assign output_6 = o[6];
  assign output_7 = o[7];
  assign output_8 = o[8];
  assign output_9 = o[9];
  assign output_10 = o[10];
  assign output_11 = o[11];
  assign output_12 = o[12];
  assign output_13 = o[13];
  assign {output_13_aktv, output_12_aktv, output_11_aktv, output_10_aktv, output_9_aktv,
          output_8_aktv, output_7_aktv, output_6_aktv, output_5_aktv, output_4_aktv,
          output_3_aktv, output_2_aktv, output_1_aktv, output_0_aktv} = ak;
  assign {pacing_13, pacing_12, pacing_11, pacing_10, pacing_9, pacing_8, pacing_7,
          pacing_6, pacing_5, pacing_4, pacing_3, pacing_2, pacing_1, pacing_0} = pac;
endmodule

// File: tb/tb_top_entity.sv
// tb_top_entity: directed stimulus against a closed-form stream model with per-cycle checking.
module tb_top_entity;
  localparam int P = 500;
  logic clk = 0, rst = 0, en = 0, new_input_0 = 0;
  logic signed [63:0] input_0 = 0;
  logic signed [63:0] out [14];
  logic [13:0] ak, pac;
  logic q_push, q_pop, q_push_valid, q_pop_valid;
  logic [7:0] h_tag, g_tag, n_tag, h_t;
  logic [63:0] h, g, n;
  int ncmp = 0, nbad = 0;
  int E, n_ent, lastpp;
  logic [7:0] tagc;
  int pe [256];
  int pp [256];
  logic [13:0] epac [256];
  logic [7:0] etg [256];
  logic [7:0] ets [256];
  logic signed [63:0] ex_m [256];
  logic signed [63:0] evals [256][14];
  logic signed [63:0] pv [14];
  logic signed [63:0] xo [14];
  logic signed [63:0] phx;
  logic [13:0] xak;
  logic [7:0] xg_tag, xn_tag;
  logic [63:0] xg, xn;
  logic signed [63:0] la [9];
  logic signed [63:0] lb [5];

  always #5 clk = ~clk;

  top_entity #(.PERIOD_CYCLES(P), .QDEPTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .input_0(input_0), .new_input_0(new_input_0),
    .output_0(out[0]), .output_0_aktv(ak[0]),
    .output_1(out[1]), .output_1_aktv(ak[1]),
    .output_2(out[2]), .output_2_aktv(ak[2]),
    .output_3(out[3]), .output_3_aktv(ak[3]),
    .output_4(out[4]), .output_4_aktv(ak[4]),
    .output_5(out[5]), .output_5_aktv(ak[5]),
    .output_6(out[6]), .output_6_aktv(ak[6]),
    .output_7(out[7]), .output_7_aktv(ak[7]),
    .output_8(out[8]), .output_8_aktv(ak[8]),
    .output_9(out[9]), .output_9_aktv(ak[9]),
    .output_10(out[10]), .output_10_aktv(ak[10]),
    .output_11(out[11]), .output_11_aktv(ak[11]),
    .output_12(out[12]), .output_12_aktv(ak[12]),
    .output_13(out[13]), .output_13_aktv(ak[13]),
    .q_push(q_push), .q_pop(q_pop), .q_push_valid(q_push_valid), .q_pop_valid(q_pop_valid),
    .pacing_0(pac[0]), .pacing_1(pac[1]), .pacing_2(pac[2]), .pacing_3(pac[3]),
    .pacing_4(pac[4]), .pacing_5(pac[5]), .pacing_6(pac[6]), .pacing_7(pac[7]),
    .pacing_8(pac[8]), .pacing_9(pac[9]), .pacing_10(pac[10]), .pacing_11(pac[11]),
    .pacing_12(pac[12]), .pacing_13(pac[13]),
    .h_tag(h_tag), .h(h), .g_tag(g_tag), .g(g), .n_tag(n_tag), .n(n), .h_t(h_t)
  );

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] b);
    ncmp++;
    if (a !== b) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h (E=%0d)", nm, a, b, E);
    end
  endtask

  // Event streams in closed form: o3=3x+1, o4=x+1, o5=3x, o6=4x+2, o8=1.
  task automatic accept(input logic signed [63:0] x, input logic [13:0] pc, input logic [7:0] ts);
    logic signed [63:0] v [14];
    logic signed [63:0] xh;
    for (int i = 0; i < 14; i++) v[i] = pv[i];
    if (pc[9]) begin
      xh = pc[0] ? x : phx;
      v[9] = pv[9] + 1;
      v[10] = xh;
      v[11] = pv[7] + v[9];
      v[12] = pv[6] - xh;
      v[13] = v[11] + v[12];
    end
    if (pc[0]) begin
      v[0] = x + 1; v[1] = 2 * x; v[2] = x - 1; v[3] = 3 * x + 1; v[4] = x + 1;
      v[5] = 3 * x; v[6] = 4 * x + 2; v[7] = pv[7] + x; v[8] = 1;
      phx = x;
    end
    pe[n_ent] = E;
    pp[n_ent] = (E + 1 > lastpp + 4) ? E + 1 : lastpp + 4;
    lastpp = pp[n_ent];
    epac[n_ent] = pc;
    etg[n_ent] = tagc;
    ets[n_ent] = ts;
    ex_m[n_ent] = x;
    for (int i = 0; i < 14; i++) begin
      evals[n_ent][i] = v[i];
      pv[i] = v[i];
    end
    tagc++;
    n_ent++;
  endtask

  task automatic cyc(input logic env, input logic evv, input logic signed [63:0] xv);
    logic tk, preq, acc, busy, ppv;
    int occ, hd, bi;
    logic [7:0] eht, ehts;
    logic [63:0] eh;
    en = env; new_input_0 = evv; input_0 = xv;
    @(negedge clk);
    for (int i = 0; i < 14; i++) chk($sformatf("out%0d", i), out[i], xo[i]);
    chk("aktv", {50'b0, ak}, {50'b0, xak});
    occ = 0; hd = -1; busy = 0; bi = -1; ppv = 0;
    for (int j = 0; j < n_ent; j++) begin
      if (pp[j] > E) begin
        occ++;
        if (hd < 0) hd = j;
      end
      if (pp[j] <= E && E <= pp[j] + 2) begin
        busy = 1;
        bi = j;
      end
      if (pp[j] == E + 1) ppv = env;
    end
    tk = env && (E % P == P - 1);
    preq = env && (evv || tk);
    acc = preq && occ < 8;
    chk("q_push", {63'b0, q_push}, {63'b0, preq});
    chk("q_push_valid", {63'b0, q_push_valid}, {63'b0, acc});
    chk("q_pop", {63'b0, q_pop}, {63'b0, env && !busy});
    chk("q_pop_valid", {63'b0, q_pop_valid}, {63'b0, ppv});
    chk("pacing", {50'b0, pac}, busy ? {50'b0, epac[bi]} : 64'd0);
    eht = 0; eh = 0; ehts = 0;
`ifdef TOP_ENTITY_DEBUG_TAPS_EN
    if (hd >= 0) begin
      eht = etg[hd]; eh = ex_m[hd]; ehts = ets[hd];
    end
    chk("g_tag", {56'b0, g_tag}, {56'b0, xg_tag});
    chk("g", g, xg);
    chk("n_tag", {56'b0, n_tag}, {56'b0, xn_tag});
    chk("n", n, xn);
`else
    chk("g_tap_tied", {g_tag, n_tag, 48'b0} ^ g ^ n, 64'd0);
`endif
    chk("h_tag", {56'b0, h_tag}, {56'b0, eht});
    chk("h", h, eh);
    chk("h_t", {56'b0, h_t}, {56'b0, ehts});
    @(posedge clk);
    if (env) begin
      E++;
      xak = '0;
      for (int j = 0; j < n_ent; j++)
        if (pp[j] + 3 == E) begin
          for (int i = 0; i < 14; i++) xo[i] = evals[j][i];
          xak = epac[j];
          if (epac[j][0]) begin xg_tag = etg[j]; xg = evals[j][6]; end
          if (epac[j][9]) begin xn_tag = etg[j]; xn = evals[j][13]; end
        end
      if (acc) accept(xv, {{5{tk}}, {9{evv}}}, 8'(E - 1));
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 0; en = 0; new_input_0 = 0; input_0 = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_ent = 0; E = 0; lastpp = -100; tagc = 0; phx = 0; xak = 0;
    xg_tag = 0; xn_tag = 0; xg = 0; xn = 0;
    for (int i = 0; i < 14; i++) begin pv[i] = 0; xo[i] = 0; end
    for (int i = 0; i < 14; i++) chk($sformatf("rst_out%0d", i), out[i], 64'd0);
    chk("rst_aktv", {50'b0, ak}, 64'd0);
    chk("rst_q_push", {63'b0, q_push}, 64'd0);
    rst = 1;
  endtask

  initial begin
    // Phase A: first tick with no input, then events x=1, x=2
    do_reset();
    while (E < 498) cyc(1, 0, 0);
    chk("pre_tick_q_push", {63'b0, q_push}, 64'd0);
    while (E < 504) cyc(1, 0, 0);
    chk("tick1_aktv", {50'b0, ak}, 64'h3e00);
    lb = '{1, 0, 1, 0, 1};
    for (int i = 0; i < 5; i++) chk($sformatf("tick1_o%0d", i + 9), out[i + 9], lb[i]);
    cyc(1, 1, 1);
    repeat (6) cyc(1, 0, 0);
    la = '{2, 2, 0, 4, 2, 3, 6, 1, 1};
    for (int i = 0; i < 9; i++) chk($sformatf("x1_o%0d", i), out[i], la[i]);
    cyc(1, 1, 2);
    repeat (6) cyc(1, 0, 0);
    la = '{3, 4, 1, 7, 3, 6, 10, 3, 1};
    for (int i = 0; i < 9; i++) chk($sformatf("x2_o%0d", i), out[i], la[i]);
    repeat (3) cyc(0, 1, 99);
    cyc(1, 1, -5);
    cyc(1, 1, 64'sh7fffffffffffffff);
    repeat (12) cyc(1, 0, 0);
    // Phase B: x=1 then first tick, burst to fill the FIFO, event coincident with tick
    do_reset();
    cyc(1, 1, 1);
    while (E < 505) cyc(1, 0, 0);
    lb = '{1, 1, 2, 5, 7};
    for (int i = 0; i < 5; i++) chk($sformatf("k1_o%0d", i + 9), out[i + 9], lb[i]);
    for (int i = 0; i < 14; i++) cyc(1, 1, 64'(i + 10));
    while (E < 999) cyc(1, 0, 0);
    cyc(1, 1, 7);
    while (E < 1010) cyc(1, 0, 0);
    chk("coinc_o9", out[9], 64'd2);
    chk("coinc_o10", out[10], 64'd7);
    // Phase C: asynchronous reset in the middle of an evaluation
    cyc(1, 1, 3);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    #2 rst = 0;
    #1;
    for (int i = 0; i < 14; i++) chk($sformatf("async_out%0d", i), out[i], 64'd0);
    chk("async_aktv", {50'b0, ak}, 64'd0);
    chk("async_pacing", {50'b0, pac}, 64'd0);
    chk("async_push_valid", {63'b0, q_push_valid}, 64'd0);
    chk("async_h", h, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
